// File: rtl/jk_counter_ctrl_pkg.sv
// Shared types and constants for the JK counter sequencer.
// Optional feature macro: JK_COUNTER_CTRL_SATURATE_EN (hold at the count limit).
package jk_counter_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_UP   = 2'b01,
        OP_DOWN = 2'b10,
        OP_STOP = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10
    } state_e;

    // JK excitation pairs, packed as {J, K}
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_ff_bank.sv
// Bank of WIDTH JK flip-flops with synchronous active-low reset.
module jk_ff_bank
    import jk_counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Per-bit JK characteristic equation
    always_comb begin
        q_d = q_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            case ({j[i], k[i]})
                JK_HOLD:  q_d[i] = q_q[i];
                JK_RESET: q_d[i] = 1'b0;
                JK_SET:   q_d[i] = 1'b1;
                default:  q_d[i] = ~q_q[i];
            endcase
        end
    end

    // Flop bank
    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/jk_counter_ctrl.sv
// Command sequencer driving a JK flop counter: load / up / down / stop.
// Optional feature macro: JK_COUNTER_CTRL_SATURATE_EN (hold at the limit, adds sat).
module jk_counter_ctrl
    import jk_counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
`ifdef JK_COUNTER_CTRL_SATURATE_EN
    output logic             sat,
`endif
    output logic             tc
);

    state_e           state_q, state_d;
    cmd_op_e          mode_q, mode_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic [WIDTH-1:0] load_q, load_d;
    logic             free_q, free_d;
    logic             clr_q, clr_d;
    logic             done_q, done_d;
`ifdef JK_COUNTER_CTRL_SATURATE_EN
    logic             sat_q, sat_d;
`endif

    logic             accept;
    cmd_op_e          op;
    logic [WIDTH-1:0] tgl;
    logic             carry;
    logic [WIDTH-1:0] j, k;

    assign op     = cmd_op_e'(cmd_op);
    assign accept = cmd_valid && cmd_ready;

    // State and control registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            mode_q  <= OP_UP;
            step_q  <= '0;
            load_q  <= '0;
            free_q  <= 1'b0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef JK_COUNTER_CTRL_SATURATE_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            step_q  <= step_d;
            load_q  <= load_d;
            free_q  <= free_d;
            clr_q   <= clr_d;
            done_q  <= done_d;
`ifdef JK_COUNTER_CTRL_SATURATE_EN
            sat_q   <= sat_d;
`endif
        end
    end

    // Next state: finish the current operation, then let an accepted command override
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        step_d  = step_q;
        load_d  = load_q;
        free_d  = free_q;
        clr_d   = 1'b0;
        done_d  = 1'b0;
`ifdef JK_COUNTER_CTRL_SATURATE_EN
        sat_d   = 1'b0;
`endif
        case (state_q)
            S_LOAD: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            S_RUN: begin
`ifdef JK_COUNTER_CTRL_SATURATE_EN
                if (tc) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    sat_d   = 1'b1;
                end else
`endif
                if (!free_q) begin
                    step_d = step_q - WIDTH'(1);
                    if (step_q == WIDTH'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (accept) begin
            case (op)
                OP_LOAD: begin
                    state_d = S_LOAD;
                    load_d  = cmd_arg;
                end
                OP_UP, OP_DOWN: begin
                    state_d = S_RUN;
                    mode_d  = op;
                    step_d  = cmd_arg;
                    free_d  = (cmd_arg == '0);
                end
                default: begin
                    // STOP beats any completion landing on the same edge
                    state_d = S_IDLE;
                    step_d  = '0;
                    clr_d   = 1'b1;
                    done_d  = 1'b0;
`ifdef JK_COUNTER_CTRL_SATURATE_EN
                    sat_d   = 1'b0;
`endif
                end
            endcase
        end
    end

    // Outputs: handshake, status and per-bit J/K excitation
    always_comb begin
        cmd_ready = (state_q != S_RUN) || (op == OP_STOP);
        busy      = (state_q != S_IDLE);
        tc        = (state_q == S_RUN) &&
                    (((mode_q == OP_UP) && (&q)) || ((mode_q == OP_DOWN) && (~|q)));

        carry = 1'b1;
        tgl   = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            tgl[i] = carry;
            carry  = carry & ((mode_q == OP_UP) ? q[i] : ~q[i]);
        end

        j = '0;
        k = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (clr_q) begin
                {j[i], k[i]} = JK_RESET;
            end else if (state_q == S_LOAD) begin
                {j[i], k[i]} = load_q[i] ? JK_SET : JK_RESET;
            end else if (state_q == S_RUN) begin
`ifdef JK_COUNTER_CTRL_SATURATE_EN
                {j[i], k[i]} = (tgl[i] && !tc) ? JK_TOGGLE : JK_HOLD;
`else
                {j[i], k[i]} = tgl[i] ? JK_TOGGLE : JK_HOLD;
`endif
            end else begin
                {j[i], k[i]} = JK_HOLD;
            end
        end
    end

    assign done = done_q;
`ifdef JK_COUNTER_CTRL_SATURATE_EN
    assign sat  = sat_q;
`endif

    jk_ff_bank #(
        .WIDTH (WIDTH)
    ) u_bank (
        .clk   (clk),
        .reset (reset),
        .j     (j),
        .k     (k),
        .q     (q)
    );

endmodule
